// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard/stall slice of the 5-stage MIPS core.
// Holds the data-memory read-type codes (DMRd_*) used to recognise loads
// in EX, the multiply/divide unit state encoding, and a helper that sizes
// the busy down-counter from the unit latency.
package hazard_stall_unit_pkg;

    // Data-memory read type carried by the EX instruction.
    localparam logic [2:0] DMRd_NOP = 3'b000;
    localparam logic [2:0] DMRd_LW  = 3'b001;
    localparam logic [2:0] DMRd_LH  = 3'b010;
    localparam logic [2:0] DMRd_LHU = 3'b011;
    localparam logic [2:0] DMRd_LB  = 3'b100;
    localparam logic [2:0] DMRd_LBU = 3'b101;

    // Multiply/divide unit occupancy.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Bits needed to hold MD_LAT-1 (at least one bit).
    function automatic int unsigned md_cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_timer.sv
// md_busy_timer: occupancy tracker for the multi-cycle multiply/divide unit.
// A start strobe in IDLE opens a busy window of exactly MD_LAT cycles; the
// cycle after the window closes carries a registered one-cycle done pulse.
// Ports:
//   clk    in   core clock
//   rstn   in   asynchronous active-low reset (aborts a window, no done)
//   start  in   accepted start strobe (only honoured in IDLE)
//   busy   out  unit occupied
//   done   out  one-cycle pulse after the busy window ends
module md_busy_timer
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LAT = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = md_cnt_width(MD_LAT);

    md_state_e       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            done_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= MD_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // cnt is loaded with MD_LAT-1 and the BUSY state is left on the edge
    // where it reads zero, giving MD_LAT busy cycles in total.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CW'(MD_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = MD_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline hazard controller beside the ID stage.
// Stalls the front end on load-use and multiply/divide-busy hazards,
// squashes wrong-path instructions on a taken branch, gates the start of
// the multiply/divide unit and counts stalled cycles (saturating).
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   IFID_rs/rt, use_rs/rt     source operands of the ID instruction
//   IFID_md_start/hilo_rd     ID instruction is mult/div or mfhi/mflo
//   IDEXE_DMRd, IDEXE_rd      load type and destination of EX instruction
//   EXE_br_taken              branch/jump resolved taken in EX
//   PC_Wr, IFID_Wr            write enables (0 = hold)
//   IFID_flush, IDEXE_flush   bubble injection controls
//   md_start, md_busy, md_done multiply/divide unit control and status
//   stall_cnt                 saturating count of cycles with PC_Wr = 0
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_use_rs,
    input  logic             IFID_use_rt,
    input  logic             IFID_md_start,
    input  logic             IFID_hilo_rd,
    input  logic [2:0]       IDEXE_DMRd,
    input  logic [4:0]       IDEXE_rd,
    input  logic             EXE_br_taken,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_flush,
    output logic             IDEXE_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    logic lu_hazard;
    logic md_hazard;
    logic stall;

    // $0 is never a real dependency, so a load targeting it cannot stall.
    always_comb begin
        lu_hazard = (IDEXE_DMRd != DMRd_NOP) && (IDEXE_rd != 5'd0) &&
                    ((IFID_use_rs && (IDEXE_rd == IFID_rs)) ||
                     (IFID_use_rt && (IDEXE_rd == IFID_rt)));
        md_hazard = md_busy && (IFID_md_start || IFID_hilo_rd);
        stall     = (lu_hazard || md_hazard) && !EXE_br_taken;
    end

    always_comb begin
        PC_Wr       = 1'b1;
        IFID_Wr     = 1'b1;
        IFID_flush  = 1'b0;
        IDEXE_flush = 1'b0;
        if (EXE_br_taken) begin
            IFID_flush  = 1'b1;
            IDEXE_flush = 1'b1;
        end else if (stall) begin
            PC_Wr       = 1'b0;
            IFID_Wr     = 1'b0;
            IDEXE_flush = 1'b1;
        end
    end

    // A stalled or squashed mult/div must not reach the unit; md_hazard
    // also keeps a second start out while the unit is busy.
    assign md_start = IFID_md_start && !stall && !EXE_br_taken;

    md_busy_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_timer (
        .clk   (clk),
        .rstn  (rstn),
        .start (md_start),
        .busy  (md_busy),
        .done  (md_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (!PC_Wr && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit. A default-parameter instance
// covers hazards and multiply/divide timing; a second instance with a
// 2-bit stall counter, sharing the load-use and branch inputs, exercises
// counter saturation.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    logic       clk;
    logic       rstn;
    logic [4:0] IFID_rs, IFID_rt;
    logic       IFID_use_rs, IFID_use_rt;
    logic       IFID_md_start, IFID_hilo_rd;
    logic [2:0] IDEXE_DMRd;
    logic [4:0] IDEXE_rd;
    logic       EXE_br_taken;

    logic        PC_Wr, IFID_Wr, IFID_flush, IDEXE_flush;
    logic        md_start, md_busy, md_done;
    logic [31:0] stall_cnt;

    logic       s_PC_Wr, s_IFID_Wr, s_IFID_flush, s_IDEXE_flush;
    logic       s_md_start, s_md_busy, s_md_done;
    logic [1:0] s_stall_cnt;

    int unsigned total_cnt;
    int unsigned pass_cnt;

    hazard_stall_unit #(
        .MD_LAT (32),
        .CNT_W  (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .IFID_rs       (IFID_rs),
        .IFID_rt       (IFID_rt),
        .IFID_use_rs   (IFID_use_rs),
        .IFID_use_rt   (IFID_use_rt),
        .IFID_md_start (IFID_md_start),
        .IFID_hilo_rd  (IFID_hilo_rd),
        .IDEXE_DMRd    (IDEXE_DMRd),
        .IDEXE_rd      (IDEXE_rd),
        .EXE_br_taken  (EXE_br_taken),
        .PC_Wr         (PC_Wr),
        .IFID_Wr       (IFID_Wr),
        .IFID_flush    (IFID_flush),
        .IDEXE_flush   (IDEXE_flush),
        .md_start      (md_start),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .stall_cnt     (stall_cnt)
    );

    hazard_stall_unit #(
        .MD_LAT (4),
        .CNT_W  (2)
    ) sat (
        .clk           (clk),
        .rstn          (rstn),
        .IFID_rs       (IFID_rs),
        .IFID_rt       (IFID_rt),
        .IFID_use_rs   (IFID_use_rs),
        .IFID_use_rt   (IFID_use_rt),
        .IFID_md_start (1'b0),
        .IFID_hilo_rd  (1'b0),
        .IDEXE_DMRd    (IDEXE_DMRd),
        .IDEXE_rd      (IDEXE_rd),
        .EXE_br_taken  (EXE_br_taken),
        .PC_Wr         (s_PC_Wr),
        .IFID_Wr       (s_IFID_Wr),
        .IFID_flush    (s_IFID_flush),
        .IDEXE_flush   (s_IDEXE_flush),
        .md_start      (s_md_start),
        .md_busy       (s_md_busy),
        .md_done       (s_md_done),
        .stall_cnt     (s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lu();
        IDEXE_DMRd  = DMRd_NOP;
        IDEXE_rd    = 5'd0;
        IFID_rs     = 5'd0;
        IFID_rt     = 5'd0;
        IFID_use_rs = 1'b0;
        IFID_use_rt = 1'b0;
    endtask

    task automatic set_lu_rt8();
        IDEXE_DMRd  = DMRd_LW;
        IDEXE_rd    = 5'd8;
        IFID_rt     = 5'd8;
        IFID_use_rt = 1'b1;
    endtask

    initial begin
        total_cnt     = 0;
        pass_cnt      = 0;
        rstn          = 1'b0;
        IFID_md_start = 1'b0;
        IFID_hilo_rd  = 1'b0;
        EXE_br_taken  = 1'b0;
        clear_lu();

        // Reset state with idle inputs
        repeat (2) tick();
        chk("rst_pc_wr",      PC_Wr,       1);
        chk("rst_ifid_wr",    IFID_Wr,     1);
        chk("rst_ifid_flush", IFID_flush,  0);
        chk("rst_idexe_flush",IDEXE_flush, 0);
        chk("rst_md_start",   md_start,    0);
        chk("rst_md_busy",    md_busy,     0);
        chk("rst_md_done",    md_done,     0);
        chk("rst_stall_cnt",  stall_cnt,   0);
        chk("rst_sat_outs",   {s_PC_Wr, s_IFID_Wr, s_IFID_flush, s_IDEXE_flush,
                               s_md_start, s_md_busy, s_md_done, s_stall_cnt},
                              {7'b1100000, 2'b00});
        rstn = 1'b1;
        tick();

        // Load-use on rt: exactly one stall cycle
        set_lu_rt8();
        #1;
        chk("lu_pc_wr",       PC_Wr,       0);
        chk("lu_ifid_wr",     IFID_Wr,     0);
        chk("lu_idexe_flush", IDEXE_flush, 1);
        chk("lu_ifid_flush",  IFID_flush,  0);
        tick();
        IDEXE_DMRd = DMRd_NOP;
        #1;
        chk("lu_after_pc_wr", PC_Wr,       1);
        chk("lu_stall_cnt",   stall_cnt,   1);
        chk("lu_sat_cnt",     s_stall_cnt, 1);
        clear_lu();

        // Register $0 never stalls; unused operand never stalls
        IDEXE_DMRd  = DMRd_LB;
        IDEXE_rd    = 5'd0;
        IFID_rs     = 5'd0;
        IFID_use_rs = 1'b1;
        #1;
        chk("zero_reg_pc_wr", PC_Wr, 1);
        IDEXE_rd    = 5'd5;
        IFID_rs     = 5'd5;
        IFID_use_rs = 1'b0;
        #1;
        chk("unused_rs_pc_wr", PC_Wr, 1);
        IDEXE_DMRd  = DMRd_LHU;
        IFID_use_rs = 1'b1;
        #1;
        chk("lu_rs_flush", IDEXE_flush, 1);
        clear_lu();
        tick();
        chk("no_stall_cnt", stall_cnt, 1);

        // Branch overrides a load-use hazard
        set_lu_rt8();
        EXE_br_taken = 1'b1;
        #1;
        chk("br_lu_pc_wr",       PC_Wr,       1);
        chk("br_lu_ifid_wr",     IFID_Wr,     1);
        chk("br_lu_ifid_flush",  IFID_flush,  1);
        chk("br_lu_idexe_flush", IDEXE_flush, 1);
        tick();
        EXE_br_taken = 1'b0;
        clear_lu();
        #1;
        chk("br_lu_stall_cnt", stall_cnt, 1);

        // Branch squashes a multiply start
        IFID_md_start = 1'b1;
        EXE_br_taken  = 1'b1;
        #1;
        chk("br_sq_md_start", md_start, 0);
        tick();
        chk("br_sq_md_busy", md_busy, 0);

        // Start accepted at edge N, mflo waiting in ID
        EXE_br_taken = 1'b0;
        #1;
        chk("md_start_ok", md_start, 1);
        tick();
        IFID_md_start = 1'b0;
        IFID_hilo_rd  = 1'b1;
        for (int unsigned k = 1; k <= 32; k++) begin
            EXE_br_taken  = (k == 3);
            IFID_md_start = (k == 10);
            #1;
            chk($sformatf("md_busy_c%0d", k), md_busy, 1);
            chk($sformatf("md_done_c%0d", k), md_done, 0);
            chk($sformatf("md_pc_wr_c%0d", k), PC_Wr, (k == 3) ? 1 : 0);
            if (k == 10) chk("md_restart_blocked", md_start, 0);
            tick();
        end
        EXE_br_taken  = 1'b0;
        IFID_md_start = 1'b0;
        #1;
        chk("md_end_busy",      md_busy,   0);
        chk("md_end_done",      md_done,   1);
        chk("md_mflo_issue",    PC_Wr,     1);
        chk("md_end_stall_cnt", stall_cnt, 32);
        tick();
        IFID_hilo_rd = 1'b0;
        #1;
        chk("md_done_pulse_end", md_done, 0);

        // Reset at cycle N+10 of a multiply
        IFID_md_start = 1'b1;
        #1;
        chk("md2_start", md_start, 1);
        tick();
        IFID_md_start = 1'b0;
        repeat (9) tick();
        chk("md2_busy_c10", md_busy, 1);
        rstn = 1'b0;
        #1;
        chk("md2_rst_busy",  md_busy,   0);
        chk("md2_rst_cnt",   stall_cnt, 0);
        tick();
        rstn = 1'b1;
        for (int unsigned k = 0; k < 26; k++) begin
            chk($sformatf("md2_no_done_%0d", k), md_done | md_busy, 0);
            tick();
        end

        // Counter saturation on the 2-bit instance
        set_lu_rt8();
        tick();
        tick();
        chk("sat_cnt_2", s_stall_cnt, 2);
        tick();
        chk("sat_cnt_3", s_stall_cnt, 3);
        tick();
        chk("sat_cnt_hold", s_stall_cnt, 3);
        chk("sat_main_cnt", stall_cnt, 4);
        clear_lu();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage MIPS core. It is the counterpart to operand forwarding: where forwarding cannot resolve a dependency, this block holds the front end and injects bubbles. It also tracks the multi-cycle multiply/divide unit and squashes wrong-path instructions on a taken branch. It sits beside the ID stage and drives the PC, IF/ID and ID/EXE pipeline-register controls.

## Interface
Parameters:
- MD_LAT, default 32: number of cycles the multiply/divide unit is busy after a start.
- CNT_W, default 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- IFID_rs  in  5  rs field of the instruction in ID.
- IFID_rt  in  5  rt field of the instruction in ID.
- IFID_use_rs  in  1  the ID instruction reads rs as a register operand.
- IFID_use_rt  in  1  the ID instruction reads rt as a register operand.
- IFID_md_start  in  1  the ID instruction is mult/multu/div/divu.
- IFID_hilo_rd  in  1  the ID instruction is mfhi/mflo.
- IDEXE_DMRd  in  3  load type of the EX instruction (`DMRd_NOP` = not a load).
- IDEXE_rd  in  5  destination register of the EX instruction.
- EXE_br_taken  in  1  the branch or jump resolved in EX is taken.
- PC_Wr  out  1  PC write enable; 0 holds the PC.
- IFID_Wr  out  1  IF/ID write enable; 0 holds IF/ID.
- IFID_flush  out  1  zero IF/ID on the next edge.
- IDEXE_flush  out  1  load a bubble (all write enables off) into ID/EXE.
- md_start  out  1  one-cycle start strobe to the multiply/divide unit.
- md_busy  out  1  the multiply/divide unit is occupied.
- md_done  out  1  registered one-cycle pulse when the busy window ends.
- stall_cnt  out  CNT_W  count of cycles with PC_Wr=0, saturating.

## Operation
- **Load-use hazard (lu):** `IDEXE_DMRd != DMRd_NOP` and `IDEXE_rd != 0`, and either (`IFID_use_rs` and `IDEXE_rd == IFID_rs`) or (`IFID_use_rt` and `IDEXE_rd == IFID_rt`).
- **Multiply/divide hazard (mh):** `md_busy` and (`IFID_md_start` or `IFID_hilo_rd`).
- **Stall:** stall = (lu | mh) & !EXE_br_taken. While stalled, PC_Wr=0, IFID_Wr=0, IDEXE_flush=1.
- **Taken branch:** EXE_br_taken drives PC_Wr=1, IFID_Wr=1, IFID_flush=1, IDEXE_flush=1. It overrides any stall.
- **Default:** PC_Wr=1, IFID_Wr=1, both flushes 0.
- **Start acceptance:** md_start = IFID_md_start & !stall & !EXE_br_taken. A squashed or stalled instruction never starts the unit.
- **Multiply/divide FSM:**
  - IDLE: on md_start, load cnt = MD_LAT-1 and go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt == 0, go to IDLE and assert md_done on the next cycle.
  - md_busy = (state == BUSY).
  - A start can only be accepted from IDLE, because mh blocks md_start while BUSY.
  - The busy window is exactly MD_LAT cycles.
- **Counter:** stall_cnt increments on every edge where PC_Wr=0 and holds at all-ones.
- **Combinational outputs:** PC_Wr, IFID_Wr, IFID_flush, IDEXE_flush and md_start are combinational.
- **Registered outputs:** state, cnt, md_done and stall_cnt are registered.

## Timing
- **Reset:** while rstn=0, state=IDLE, cnt=0, md_done=0, stall_cnt=0. With idle inputs the outputs are PC_Wr=1, IFID_Wr=1, IFID_flush=0, IDEXE_flush=0, md_start=0, md_busy=0.
- **Reset mid-operation:** reset while BUSY aborts to IDLE with no md_done pulse.
- **Load-use:** the stall lasts exactly one cycle, because the load moves to MEM and the forwarding path covers it afterwards.
- **Multiply/divide:**
  - Start accepted at edge N: md_busy is high for cycles N+1 through N+MD_LAT.
  - md_done is high in cycle N+MD_LAT+1.
  - An mfhi in ID issues in cycle N+MD_LAT+1.
- **Branch while BUSY:** a taken branch in EX does not cancel an accepted multiply/divide; the unit keeps counting.

## Structure
- **Shared constants:** add `MD_IDLE` and `MD_BUSY` to ctrl_encode_def.v. `DMRd_NOP` is reused from there.
- **Sub-module:** `md_busy_timer` (FSM plus down-counter, outputs md_busy and md_done). The top level keeps the hazard logic and stall_cnt.

## Test plan
- **Load-use stall:** IDEXE_DMRd=LW, IDEXE_rd=8, IFID_rt=8, use_rt=1 → exactly one cycle of PC_Wr=0, IFID_Wr=0, IDEXE_flush=1; stall_cnt 0→1.
- **No stall for $0:** IDEXE_rd=0 with a matching rs → no stall.
- **Multiply/divide timing:** md start at edge N with MD_LAT=32, followed by mflo in ID → PC_Wr=0 for cycles N+1..N+32; md_done high only in N+33; mflo issues in N+33.
- **Branch overrides load-use:** EXE_br_taken together with a load-use hazard → PC_Wr=1, IFID_flush=1, IDEXE_flush=1; stall_cnt unchanged.
- **Branch squashes a start:** EXE_br_taken with IFID_md_start=1 → md_start=0 and state stays IDLE.
- **Reset mid-multiply:** rstn low at cycle N+10 of a multiply → md_busy=0 immediately, no md_done pulse. stall_cnt is forced to CNT_W'hFFFF_FFFF-1 and two stall cycles are applied → counter ends at all-ones.
